// File: rtl/matrix_operand_loader.sv
// Deserializes an 18-element byte stream (matrix A then B, row-major) into held parallel operands.
// Optional s_last framing check enabled by defining LOADER_FRAME_CHECK_EN.
module matrix_operand_loader #(
    parameter int ELEM_W = 8,
    parameter int N_ELEM = 9
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ELEM_W-1:0]        s_data,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic                     s_last,
    output logic [N_ELEM*ELEM_W-1:0] a_flat,
    output logic [N_ELEM*ELEM_W-1:0] b_flat,
    output logic                     operand_valid,
    input  logic                     operand_ack,
    output logic                     frame_err
);
    localparam int         FRAME    = 2 * N_ELEM;
    localparam logic [4:0] LAST_IDX = 5'(FRAME - 1);

    typedef enum logic {ST_COLLECT, ST_WAIT} state_t;

    state_t                    state_reg, state_next;
    logic [4:0]                cnt_reg;
    logic                      live_reg;
    logic [ELEM_W-1:0]         coll_mem [0:FRAME-1];
    logic [N_ELEM*ELEM_W-1:0]  coll_a, coll_b, bypass_b;
    logic                      acc, at_last, frame_bad, slot_free;
    logic                      load_bypass, load_coll;

    generate
        for (genvar gi = 0; gi < N_ELEM; gi++) begin : g_pack
            assign coll_a[ELEM_W*gi +: ELEM_W] = coll_mem[gi];
            assign coll_b[ELEM_W*gi +: ELEM_W] = coll_mem[N_ELEM + gi];
        end
    endgenerate

    // The final element goes straight to b8 so the slot loads on its own accept edge.
    assign bypass_b  = {s_data, coll_b[(N_ELEM-1)*ELEM_W-1:0]};
    assign acc       = s_valid && s_ready;
    assign at_last   = (cnt_reg == LAST_IDX);
    assign slot_free = !operand_valid || operand_ack;

`ifdef LOADER_FRAME_CHECK_EN
    assign frame_bad = acc && (s_last != at_last);
`else
    logic unused_s_last;
    assign unused_s_last = s_last;
    assign frame_bad     = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_COLLECT;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        s_ready     = 1'b0;
        load_bypass = 1'b0;
        load_coll   = 1'b0;
        case (state_reg)
            ST_COLLECT: begin
                s_ready = live_reg;
                if (acc && !frame_bad && at_last) begin
                    if (slot_free) begin
                        load_bypass = 1'b1;
                    end else begin
                        state_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (operand_ack) begin
                    load_coll  = 1'b1;
                    state_next = ST_COLLECT;
                end
            end
            default: state_next = ST_COLLECT;
        endcase
    end

    // Collection buffer carries no reset: a cleared counter makes stale contents unreachable.
    always_ff @(posedge clk) begin
        if (acc && !frame_bad) begin
            coll_mem[cnt_reg] <= s_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg       <= '0;
            live_reg      <= 1'b0;
            a_flat        <= '0;
            b_flat        <= '0;
            operand_valid <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            live_reg  <= 1'b1;
            frame_err <= frame_bad;
            if (acc) begin
                cnt_reg <= (frame_bad || at_last) ? 5'd0 : cnt_reg + 5'd1;
            end
            if (load_bypass) begin
                a_flat        <= coll_a;
                b_flat        <= bypass_b;
                operand_valid <= 1'b1;
            end else if (load_coll) begin
                a_flat        <= coll_a;
                b_flat        <= coll_b;
                operand_valid <= 1'b1;
            end else if (operand_ack) begin
                operand_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_matrix_operand_loader.sv
// Directed, table-driven bench for matrix_operand_loader (both builds of LOADER_FRAME_CHECK_EN).
module tb_matrix_operand_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic        s_last = 1'b0;
    logic [71:0] a_flat, b_flat;
    logic        operand_valid;
    logic        operand_ack = 1'b0;
    logic        frame_err;

    int total = 0, passed = 0, drops = 0, ferr_seen = 0;

    typedef struct {
        logic [7:0]  start;
        bit          gaps;
        bit          ack_last;
        bit          clear_after;
        logic [71:0] exp_a;
        logic [71:0] exp_b;
    } vec_t;
    vec_t vecs[3];

    matrix_operand_loader #(.ELEM_W(8), .N_ELEM(9)) dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .s_last(s_last), .a_flat(a_flat), .b_flat(b_flat), .operand_valid(operand_valid),
        .operand_ack(operand_ack), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [71:0] got, input logic [71:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
        else passed++;
    endtask

    // Drives one element from a negedge; returns at the negedge after it is accepted.
    task automatic send(input logic [7:0] v, input logic last);
        int t = 0;
        s_data = v; s_valid = 1'b1; s_last = last;
        while (s_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("ready_timeout", {71'd0, s_ready}, 72'd1);
        if (t > 0) drops++;
        @(negedge clk);
        s_valid = 1'b0; s_last = 1'b0;
        if (frame_err === 1'b1) ferr_seen++;
    endtask

    task automatic run_frame(input vec_t v);
        for (int k = 0; k < 18; k++) begin
            if (v.gaps && (k % 3 == 2)) begin
                operand_ack = 1'b1;
                @(negedge clk);
                operand_ack = 1'b0;
                chk("idle_ack_ignored", {71'd0, operand_valid}, 72'd0);
            end
            if (v.ack_last && k == 17) operand_ack = 1'b1;
            send(v.start + 8'(k), k == 17);
            operand_ack = 1'b0;
        end
    endtask

    initial begin
        vecs[0] = '{8'd1,  1'b0, 1'b0, 1'b0, 72'h090807060504030201, 72'h1211100f0e0d0c0b0a};
        vecs[1] = '{8'd61, 1'b0, 1'b1, 1'b1, 72'h4544434241403f3e3d, 72'h4e4d4c4b4a49484746};
        vecs[2] = '{8'd5,  1'b1, 1'b0, 1'b0, 72'h0d0c0b0a0908070605, 72'h161514131211100f0e};

        repeat (2) @(negedge clk);
        chk("reset_a", a_flat, 72'd0);
        chk("reset_b", b_flat, 72'd0);
        chk("reset_valid", {71'd0, operand_valid}, 72'd0);
        chk("reset_ferr", {71'd0, frame_err}, 72'd0);
        chk("reset_ready", {71'd0, s_ready}, 72'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 3; i++) begin
            drops = 0;
            run_frame(vecs[i]);
            chk($sformatf("v%0d_a", i), a_flat, vecs[i].exp_a);
            chk($sformatf("v%0d_b", i), b_flat, vecs[i].exp_b);
            chk($sformatf("v%0d_valid", i), {71'd0, operand_valid}, 72'd1);
            chk($sformatf("v%0d_ready_drops", i), 72'(drops), 72'd0);
            chk($sformatf("v%0d_ready", i), {71'd0, s_ready}, 72'd1);
            if (vecs[i].clear_after) begin
                operand_ack = 1'b1;
                @(negedge clk);
                operand_ack = 1'b0;
                chk($sformatf("v%0d_ack_clears", i), {71'd0, operand_valid}, 72'd0);
                chk($sformatf("v%0d_ack_keeps_a", i), a_flat, vecs[i].exp_a);
            end
            if (i == 0) begin
                // Second frame with no ack: buffer fills and the loader stalls.
                for (int k = 0; k < 18; k++) send(8'd21 + 8'(k), k == 17);
                chk("wait_ready_low", {71'd0, s_ready}, 72'd0);
                chk("wait_hold_a", a_flat, vecs[0].exp_a);
                repeat (2) @(negedge clk);
                chk("wait_hold_b", b_flat, vecs[0].exp_b);
                chk("wait_hold_valid", {71'd0, operand_valid}, 72'd1);
                operand_ack = 1'b1;
                @(negedge clk);
                operand_ack = 1'b0;
                chk("wait_ack_a", a_flat, 72'h1d1c1b1a1918171615);
                chk("wait_ack_b", b_flat, 72'h262524232221201f1e);
                chk("wait_ack_valid", {71'd0, operand_valid}, 72'd1);
                chk("wait_ack_ready", {71'd0, s_ready}, 72'd1);
            end
        end

        // Reset in the middle of a frame.
        for (int k = 0; k < 5; k++) send(8'd90 + 8'(k), 1'b0);
        rst = 1'b1;
        #1;
        chk("midrst_a", a_flat, 72'd0);
        chk("midrst_b", b_flat, 72'd0);
        chk("midrst_valid", {71'd0, operand_valid}, 72'd0);
        chk("midrst_ready", {71'd0, s_ready}, 72'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 18; k++) send(8'd40 + 8'(k), k == 17);
        chk("postrst_a", a_flat, 72'h302f2e2d2c2b2a2928);
        chk("postrst_b", b_flat, 72'h393837363534333231);
        chk("postrst_valid", {71'd0, operand_valid}, 72'd1);
        operand_ack = 1'b1;
        @(negedge clk);
        operand_ack = 1'b0;

`ifdef LOADER_FRAME_CHECK_EN
        for (int k = 0; k < 10; k++) send(8'd1 + 8'(k), k == 9);
        chk("short_ferr_pulse", {71'd0, frame_err}, 72'd1);
        @(negedge clk);
        chk("short_ferr_one_cycle", {71'd0, frame_err}, 72'd0);
        chk("short_no_valid", {71'd0, operand_valid}, 72'd0);
        ferr_seen = 0;
        for (int k = 0; k < 18; k++) send(8'd100 + 8'(k), k == 17);
`else
        ferr_seen = 0;
        for (int k = 0; k < 18; k++) send(8'd100 + 8'(k), k == 9 || k == 17);
`endif
        chk("final_a", a_flat, 72'h6c6b6a696867666564);
        chk("final_b", b_flat, 72'h7574737271706f6e6d);
        chk("final_valid", {71'd0, operand_valid}, 72'd1);
        chk("final_no_ferr", 72'(ferr_seen), 72'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
